// File: rtl/polaris_bus_pkg.sv
// polaris_bus_pkg: shared bus FSM state encoding and transfer size codes
package polaris_bus_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_IGNT = 2'b01;
  localparam logic [1:0] ST_DGNT = 2'b10;
  localparam logic [1:0] SIZ_B = 2'b00;
  localparam logic [1:0] SIZ_H = 2'b01;
  localparam logic [1:0] SIZ_W = 2'b10;
  localparam logic [1:0] SIZ_D = 2'b11;
endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates I-fetch and D-access masters onto one bus (fixed D priority).
// Define ARB_RR_EN to alternate grants on simultaneous requests instead.
module bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int ADR_W = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [ADR_W-1:0] iadr_i,
  input  logic [1:0]       isiz_i,
  output logic             iack_o,
  output logic [31:0]      idat_o,
  input  logic [ADR_W-1:0] dadr_i,
  input  logic [63:0]      ddat_i,
  output logic [63:0]      ddat_o,
  input  logic             dwe_i,
  input  logic             dcyc_i,
  input  logic             dstb_i,
  input  logic [1:0]       dsiz_i,
  input  logic             dsigned_i,
  output logic             dack_o,
  output logic [ADR_W-1:0] madr_o,
  output logic [63:0]      mdat_o,
  input  logic [63:0]      mdat_i,
  output logic             mwe_o,
  output logic             mcyc_o,
  output logic             mstb_o,
  output logic             msigned_o,
  output logic [1:0]       msiz_o,
  input  logic             mack_i,
  output logic [1:0]       gnt_o
);
  logic [1:0] state, next;
  logic ireq, dreq, d_first, ig, dg;
  assign ireq = |isiz_i;
  assign dreq = dcyc_i;
`ifdef ARB_RR_EN
  logic last_d;
  assign d_first = !last_d;
  always_ff @(posedge clk_i)
    if (reset_i) last_d <= 1'b0;
    else if (state == ST_IDLE && next != ST_IDLE) last_d <= next == ST_DGNT;
`else
  assign d_first = 1'b1;
`endif
  always_comb
    next = state == ST_IDLE ? (dreq && (d_first || !ireq) ? ST_DGNT : ireq ? ST_IGNT : ST_IDLE)
         : state == ST_DGNT ? (dreq ? ST_DGNT : ST_IDLE)
         : state == ST_IGNT ? (mack_i || !ireq ? ST_IDLE : ST_IGNT)
         : ST_IDLE;
  always_ff @(posedge clk_i)
    if (reset_i) state <= ST_IDLE;
    else state <= next;
  assign ig = state == ST_IGNT;
  assign dg = state == ST_DGNT;
  assign gnt_o = state;
  assign madr_o = dg ? dadr_i : ig ? iadr_i : '0;
  assign mdat_o = dg ? ddat_i : '0;
  assign mwe_o = dg & dwe_i;
  assign mcyc_o = dg ? dcyc_i : ig & ireq;
  assign mstb_o = dg ? dstb_i : ig & ireq;
  assign msiz_o = dg ? dsiz_i : ig ? isiz_i : '0;
  assign msigned_o = dg & dsigned_i;
  // acks are gated by the owner's live request so a dropped cycle never sees a late ack
  assign dack_o = dg & dcyc_i & mack_i;
  assign ddat_o = dg ? mdat_i : '0;
  assign iack_o = ig & ireq & mack_i;
  assign idat_o = ig ? (iadr_i[2] ? mdat_i[63:32] : mdat_i[31:0]) : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random traffic checked against an owner-based reference model.
module tb_bus_arbiter;
  logic clk = 1'b0, reset_i = 1'b1;
  logic [63:0] iadr_i = '0, dadr_i = '0, ddat_i = '0, mdat_i = '0;
  logic [1:0] isiz_i = '0, dsiz_i = '0;
  logic dwe_i = 0, dcyc_i = 0, dstb_i = 0, dsigned_i = 0, mack_i = 0;
  logic iack_o, dack_o, mwe_o, mcyc_o, mstb_o, msigned_o;
  logic [31:0] idat_o;
  logic [63:0] ddat_o, madr_o, mdat_o;
  logic [1:0] msiz_o, gnt_o;
  int tests = 0, fails = 0;
  int owner = 0;
  bit last_d = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.ADR_W(64)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
    .dadr_i(dadr_i), .ddat_i(ddat_i), .ddat_o(ddat_o), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
    .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .dack_o(dack_o),
    .madr_o(madr_o), .mdat_o(mdat_o), .mdat_i(mdat_i), .mwe_o(mwe_o), .mcyc_o(mcyc_o),
    .mstb_o(mstb_o), .msigned_o(msigned_o), .msiz_o(msiz_o), .mack_i(mack_i), .gnt_o(gnt_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // owner: 0 nobody, 1 I-side, 2 D-side
  task automatic check_all();
    logic [63:0] e_madr = '0, e_mdat = '0, e_ddat = '0;
    logic [31:0] e_idat = '0;
    logic [1:0] e_msiz = '0;
    logic e_mwe = 0, e_mcyc = 0, e_mstb = 0, e_msg = 0, e_iack = 0, e_dack = 0;
    if (owner == 2) begin
      e_madr = dadr_i; e_mdat = ddat_i; e_mwe = dwe_i; e_mcyc = dcyc_i; e_mstb = dstb_i;
      e_msiz = dsiz_i; e_msg = dsigned_i; e_dack = mack_i && dcyc_i; e_ddat = mdat_i;
    end else if (owner == 1) begin
      e_madr = iadr_i; e_mcyc = isiz_i != 0; e_mstb = isiz_i != 0; e_msiz = isiz_i;
      e_iack = mack_i && isiz_i != 0;
      e_idat = iadr_i[2] ? mdat_i[63:32] : mdat_i[31:0];
    end
    chk("gnt", 64'(gnt_o), 64'(owner));
    chk("madr", madr_o, e_madr);
    chk("mdat", mdat_o, e_mdat);
    chk("mwe", 64'(mwe_o), 64'(e_mwe));
    chk("mcyc", 64'(mcyc_o), 64'(e_mcyc));
    chk("mstb", 64'(mstb_o), 64'(e_mstb));
    chk("msiz", 64'(msiz_o), 64'(e_msiz));
    chk("msigned", 64'(msigned_o), 64'(e_msg));
    chk("iack", 64'(iack_o), 64'(e_iack));
    chk("dack", 64'(dack_o), 64'(e_dack));
    chk("idat", 64'(idat_o), 64'(e_idat));
    chk("ddat", ddat_o, e_ddat);
  endtask
  function automatic void model_update();
    bit ireq = isiz_i != 0;
    if (reset_i) begin
      owner = 0;
      last_d = 0;
    end else if (owner == 0) begin
      if (dcyc_i && ireq) begin
`ifdef ARB_RR_EN
        owner = last_d ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (dcyc_i) owner = 2;
      else if (ireq) owner = 1;
      if (owner != 0) last_d = owner == 2;
    end else if (owner == 1) begin
      if (mack_i || !ireq) owner = 0;
    end else if (!dcyc_i) owner = 0;
  endfunction
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask
  initial begin
    tick();
    tick();
    reset_i = 0;
    #1 chk("reset_gnt", 64'(gnt_o), 64'd0);
    // fetch of upper word, acked in cycle 3
    isiz_i = 2'b10; iadr_i = 64'h1004;
    tick();
    chk("r24_mcyc1", 64'(mcyc_o), 64'd1);
    tick();
    chk("r24_mcyc2", 64'(mcyc_o), 64'd1);
    tick();
    mack_i = 1; mdat_i = 64'hAAAA_BBBB_CCCC_DDDD;
    #1 chk("r24_iack", 64'(iack_o), 64'd1);
    chk("r24_idat", 64'(idat_o), 64'hAAAA_BBBB);
    tick();
    mack_i = 0; isiz_i = 0;
    #1 chk("r24_idle", 64'(gnt_o), 64'd0);
    tick();
    // D write
    dcyc_i = 1; dstb_i = 1; dwe_i = 1; dadr_i = 64'h2000; ddat_i = 64'h1122_3344_5566_7788; dsiz_i = 2'b11;
    tick();
    chk("r25_madr", madr_o, 64'h2000);
    chk("r25_mwe", 64'(mwe_o), 64'd1);
    tick();
    mack_i = 1;
    #1 chk("r25_dack", 64'(dack_o), 64'd1);
    chk("r25_mdat", mdat_o, 64'h1122_3344_5566_7788);
    tick();
    mack_i = 0; dcyc_i = 0; dstb_i = 0; dwe_i = 0;
    tick();
    chk("r25_idle", 64'(gnt_o), 64'd0);
    // simultaneous requests, last grant was D
    dcyc_i = 1; dstb_i = 1; isiz_i = 2'b10; iadr_i = 64'h3000;
    tick();
    mack_i = 1;
`ifdef ARB_RR_EN
    #1 chk("r26_first", 64'(gnt_o), 64'd1);
    chk("r26_iack", 64'(iack_o), 64'd1);
    tick();
    mack_i = 0; isiz_i = 0;
    #1 chk("r26_gap", 64'(gnt_o), 64'd0);
    tick();
    chk("r26_second", 64'(gnt_o), 64'd2);
    mack_i = 1;
    tick();
    dcyc_i = 0; dstb_i = 0; mack_i = 0;
    tick();
`else
    #1 chk("r26_first", 64'(gnt_o), 64'd2);
    chk("r26_dack", 64'(dack_o), 64'd1);
    tick();
    dcyc_i = 0; dstb_i = 0; mack_i = 0;
    #1 chk("r26_hold", 64'(gnt_o), 64'd2);
    tick();
    chk("r26_gap", 64'(gnt_o), 64'd0);
    tick();
    chk("r26_second", 64'(gnt_o), 64'd1);
    mack_i = 1;
    #1 chk("r26_iack", 64'(iack_o), 64'd1);
    tick();
    isiz_i = 0; mack_i = 0;
    tick();
`endif
    // locked two-beat D cycle with I waiting
    dcyc_i = 1; dstb_i = 1;
    tick();
    isiz_i = 2'b01; iadr_i = 64'h40; mack_i = 1;
    #1 chk("r27_beat1", 64'(gnt_o), 64'd2);
    tick();
    chk("r27_beat2", 64'(gnt_o), 64'd2);
    chk("r27_dack2", 64'(dack_o), 64'd1);
    tick();
    mack_i = 0; dcyc_i = 0; dstb_i = 0;
    #1 chk("r27_hold", 64'(gnt_o), 64'd2);
    tick();
    chk("r27_gap", 64'(gnt_o), 64'd0);
    tick();
    chk("r27_igrant", 64'(gnt_o), 64'd1);
    mack_i = 1;
    #1 chk("r27_iack", 64'(iack_o), 64'd1);
    tick();
    mack_i = 0; isiz_i = 0;
    tick();
    // reset in the middle of an un-acked D cycle
    dcyc_i = 1; dstb_i = 1; dwe_i = 1;
    tick();
    chk("r28_mcyc", 64'(mcyc_o), 64'd1);
    tick();
    reset_i = 1;
    tick();
    reset_i = 0; mack_i = 1;
    #1 chk("r28_gnt", 64'(gnt_o), 64'd0);
    chk("r28_mcyc0", 64'(mcyc_o), 64'd0);
    chk("r28_dack", 64'(dack_o), 64'd0);
    dcyc_i = 0; dstb_i = 0; dwe_i = 0;
    tick();
    mack_i = 0;
    // abandoned fetch
    isiz_i = 2'b01; iadr_i = 64'h8;
    tick();
    chk("r29_mcyc1", 64'(mcyc_o), 64'd1);
    isiz_i = 0; mack_i = 1;
    #1 chk("r29_mcyc0", 64'(mcyc_o), 64'd0);
    chk("r29_iack", 64'(iack_o), 64'd0);
    tick();
    mack_i = 0;
    chk("r29_idle", 64'(gnt_o), 64'd0);
    for (int k = 0; k < 400; k++) begin
      reset_i = $urandom_range(49) == 0;
      dcyc_i = dcyc_i ? $urandom_range(3) != 0 : $urandom_range(2) == 0;
      dstb_i = 1'($urandom_range(1));
      dwe_i = 1'($urandom_range(1));
      dsigned_i = 1'($urandom_range(1));
      dsiz_i = 2'($urandom_range(3));
      isiz_i = $urandom_range(2) == 0 ? 2'b00 : 2'($urandom_range(3));
      iadr_i = {$urandom, $urandom};
      dadr_i = {$urandom, $urandom};
      ddat_i = {$urandom, $urandom};
      mdat_i = {$urandom, $urandom};
      mack_i = $urandom_range(2) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
